access_control: RTL and testbench
=================================

Name: access_control

Overview:
- Passcode-entry stage directly downstream of the process-control FSM; produces the `access_control_fb` signal that FSM waits on before leaving its access-control state.
- User dials one digit at a time on the switches and commits each digit with a one-cycle enter pulse. Process control gates the enter path through `enable`.
- After NUM_DIGITS digits the entry is compared against a parameterised passcode. Result: grant access, or count a failure, with a timed lockout after MAX_FAILS failures.

Parameters:
- DIGIT_W, 4: bits per digit.
- NUM_DIGITS, 4: digits per passcode.
- PASSCODE, 16'h1234: expected code. First-entered digit sits in the most-significant digit slot. Width = DIGIT_W*NUM_DIGITS.
- MAX_FAILS, 3: consecutive failures that trigger lockout (range 1..7).
- LOCKOUT_CYCLES, 100000000: clock cycles spent locked. Bench overrides to 8.

Ports:
- clk, input, 1: rising-edge clock.
- rst, input, 1: synchronous, active-low reset.
- enable, input, 1: from process control; high while its FSM is in the access-control state.
- digit, input, DIGIT_W: switch value sampled on enter.
- enter, input, 1: single-cycle, already debounced/one-pulsed button.
- logout, input, 1: single-cycle pulse; revokes access.
- access_control_fb, output, 1: registered; 1 while access is granted.
- digit_count, output, 3: digits captured in the current entry (0..NUM_DIGITS-1).
- fail_count, output, 3: consecutive failures.
- locked, output, 1: high during lockout.
- status, output, 2: LCD code. 00 idle/entering, 01 granted, 10 denied, 11 locked.

Behaviour:
- Reset (rst==0 at a rising edge): state=IDLE; access_control_fb=0, digit_count=0, fail_count=0, locked=0, status=00; entry buffer and lockout timer cleared. Reset overrides everything, including mid-entry, mid-lockout and granted states.
- States: IDLE, ENTRY, CHECK, GRANTED, DENIED, LOCKED. All outputs are registered.
- Accepted digit (IDLE/ENTRY/DENIED, enable=1, enter=1):
  - shift digit into the buffer LSB side (buffer <= {buffer[rest], digit});
  - digit_count++;
  - state becomes ENTRY;
  - status=00.
- Digit completion: the NUM_DIGITS-th accepted digit moves state to CHECK and clears digit_count to 0.
- CHECK (exactly one cycle; enter ignored):
  - buffer==PASSCODE: GRANTED; access_control_fb=1, status=01, fail_count=0.
  - otherwise: fail_count++.
    - new fail_count==MAX_FAILS: LOCKED; locked=1, status=11, timer loaded.
    - else: DENIED; status=10.
- Latency: access_control_fb rises at the 2nd rising edge after the edge that samples the final enter.
- DENIED: holds until the next accepted digit, which is captured as digit 1 of a fresh entry.
- LOCKED:
  - enter and logout ignored;
  - timer counts LOCKOUT_CYCLES cycles;
  - then IDLE; locked=0, fail_count=0, status=00.
  - Timer width = $clog2(LOCKOUT_CYCLES+1).
- GRANTED:
  - enter ignored;
  - logout=1 → IDLE; access_control_fb=0, status=00, fail_count=0;
  - enable dropping does not revoke access (only logout or reset does).
- enable=0 in ENTRY: partial entry discarded at that edge (buffer cleared, digit_count=0, state IDLE).
- enable=0 in IDLE/DENIED: enter ignored; state and fail_count hold.
- enable=0 in CHECK/LOCKED: no effect.
- Simultaneous events:
  - enter+logout in GRANTED: logout wins.
  - enter+logout elsewhere: logout ignored, enter handled normally.
  - enter held high multiple cycles: each high cycle counts as a separate digit (upstream guarantees pulses).
- Any DIGIT_W value is accepted as a digit; no BCD range check.

Test Plan:
- Reset/idle: hold rst=0 3 cycles, release → all outputs 0, status=00. Pulse enter with enable=0 → digit_count stays 0.
- Correct code: enable=1, enter digits 1,2,3,4 on separate cycles → digit_count steps 1,2,3 then 0; access_control_fb=1 and status=01 two edges after the 4th enter. logout pulse → access_control_fb=0 next edge.
- Single failure: enter 1,2,3,5 → status=10, fail_count=1, access_control_fb=0. Then enter 1,2,3,4 → granted, fail_count=0.
- Lockout (LOCKOUT_CYCLES=8):
  - three wrong codes (0,0,0,0) → third CHECK gives locked=1, status=11, fail_count=3;
  - enter pulses during lockout are ignored (digit_count stays 0);
  - exactly 8 cycles later: locked=0, fail_count=0, status=00.
- Aborted entry: enter 1,2 → digit_count=2. Drop enable one cycle → digit_count=0. Re-enter 1,2,3,4 → granted.
- Edge cases:
  - while granted: drop enable → access_control_fb stays 1;
  - enter+logout same cycle → logout wins, access_control_fb=0, digit_count=0;
  - rst=0 mid-lockout → immediate IDLE, locked=0.

Source files
------------

// File: rtl/access_control.sv
// access_control: passcode entry with grant, failure counting and timed lockout
module access_control #(
  parameter int DIGIT_W = 4,
  parameter int NUM_DIGITS = 4,
  parameter logic [DIGIT_W*NUM_DIGITS-1:0] PASSCODE = 16'h1234,
  parameter int MAX_FAILS = 3,
  parameter int LOCKOUT_CYCLES = 100000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [DIGIT_W-1:0] digit,
  input  logic               enter,
  input  logic               logout,
  output logic               access_control_fb,
  output logic [2:0]         digit_count,
  output logic [2:0]         fail_count,
  output logic               locked,
  output logic [1:0]         status
);
  localparam int CODE_W = DIGIT_W * NUM_DIGITS;
  localparam int TIMER_W = $clog2(LOCKOUT_CYCLES + 1);
  localparam logic [2:0] LAST_DIGIT = 3'(NUM_DIGITS - 1);
  localparam logic [2:0] FAIL_LIMIT = 3'(MAX_FAILS);
  localparam logic [2:0] IDLE = 3'd0, ENTRY = 3'd1, CHECK = 3'd2, GRANTED = 3'd3, DENIED = 3'd4, LOCKED = 3'd5;
  logic [2:0] state;
  logic [CODE_W-1:0] buffer;
  logic [TIMER_W-1:0] timer;
  // state sequencing; visible fb/status/locked are registered decodes of the state, one edge behind it
  always_ff @(posedge clk)
    if (!rst) begin
      state <= IDLE;
      buffer <= '0;
      timer <= '0;
      digit_count <= '0;
      fail_count <= '0;
      access_control_fb <= 1'b0;
      locked <= 1'b0;
      status <= 2'b00;
    end else begin
      access_control_fb <= state == GRANTED;
      locked <= state == LOCKED;
      status <= state == GRANTED ? 2'b01 : state == LOCKED ? 2'b11 : state == DENIED ? 2'b10 : 2'b00;
      case (state)
        IDLE, ENTRY, DENIED:
          if (enable && enter) begin
            buffer <= (buffer << DIGIT_W) | CODE_W'(digit);
            digit_count <= digit_count == LAST_DIGIT ? 3'd0 : digit_count + 3'd1;
            state <= digit_count == LAST_DIGIT ? CHECK : ENTRY;
          end else if (!enable && state == ENTRY) begin
            buffer <= '0;
            digit_count <= '0;
            state <= IDLE;
          end
        CHECK:
          if (buffer == PASSCODE) begin
            state <= GRANTED;
            fail_count <= '0;
          end else begin
            fail_count <= fail_count + 3'd1;
            state <= fail_count + 3'd1 == FAIL_LIMIT ? LOCKED : DENIED;
            timer <= TIMER_W'(LOCKOUT_CYCLES - 1);
          end
        GRANTED:
          if (logout) begin
            state <= IDLE;
            fail_count <= '0;
          end
        LOCKED:
          if (timer == '0) begin
            state <= IDLE;
            fail_count <= '0;
          end else timer <= timer - 1'b1;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_access_control.sv
// tb_access_control: randomized and directed checking of access_control against a queue-based model
module tb_access_control;
  localparam int LOCK = 8;
  localparam int MAXF = 3;
  localparam logic [15:0] PASS = 16'h1234;
  logic clk = 0, rst = 0, enable = 0, enter = 0, logout = 0;
  logic [3:0] digit = 0;
  logic fb, locked;
  logic [2:0] dc, fc;
  logic [1:0] status;
  int passed = 0, total = 0;
  logic [3:0] digs[$];
  logic [15:0] code;
  bit pend = 0, granted = 0, denied = 0;
  int lock_left = 0, fails = 0;
  int m_fb = 0, m_locked = 0, m_status = 0;

  access_control #(.DIGIT_W(4), .NUM_DIGITS(4), .PASSCODE(PASS), .MAX_FAILS(MAXF), .LOCKOUT_CYCLES(LOCK)) dut (
    .clk(clk), .rst(rst), .enable(enable), .digit(digit), .enter(enter), .logout(logout),
    .access_control_fb(fb), .digit_count(dc), .fail_count(fc), .locked(locked), .status(status)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input int a, input int e);
    total++;
    if (a == e) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
  endtask

  // model: visible outputs reflect the situation before this edge, then the situation advances
  always @(posedge clk) begin
    if (!rst) begin
      digs.delete();
      pend = 0; granted = 0; denied = 0; lock_left = 0; fails = 0;
      m_fb = 0; m_locked = 0; m_status = 0;
    end else begin
      m_fb = granted;
      m_locked = lock_left > 0;
      m_status = granted ? 1 : lock_left > 0 ? 3 : denied ? 2 : 0;
      if (pend) begin
        pend = 0;
        if (code == PASS) begin granted = 1; fails = 0; end
        else begin
          fails++;
          if (fails == MAXF) lock_left = LOCK; else denied = 1;
        end
      end else if (lock_left > 0) begin
        lock_left--;
        if (lock_left == 0) fails = 0;
      end else if (granted) begin
        if (logout) begin granted = 0; fails = 0; end
      end else if (enable && enter) begin
        denied = 0;
        digs.push_back(digit);
        if (digs.size() == 4) begin
          code = 0;
          foreach (digs[i]) code = code * 16 + 16'(digs[i]);
          digs.delete();
          pend = 1;
        end
      end else if (!enable) digs.delete();
    end
  end

  always @(negedge clk) begin
    chk("fb", fb, m_fb);
    chk("locked", locked, m_locked);
    chk("status", status, m_status);
    chk("digit_count", dc, digs.size());
    chk("fail_count", fc, fails);
  end

  task automatic drive(input logic r, input logic en, input logic [3:0] d, input logic e, input logic lo);
    rst = r; enable = en; digit = d; enter = e; logout = lo;
    @(negedge clk);
  endtask

  task automatic code4(input logic [15:0] c);
    for (int i = 0; i < 4; i++) drive(1, 1, c[15-4*i -: 4], 1, 0);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1, 1, 0, 0, 0);
  endtask

  initial begin
    repeat (3) drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    chk("rst_fb", fb, 0); chk("rst_status", status, 0); chk("rst_dc", dc, 0);
    chk("rst_locked", locked, 0); chk("rst_fc", fc, 0);
    drive(1, 0, 5, 1, 0);
    chk("disabled_enter_dc", dc, 0);
    drive(1, 1, 1, 1, 0); chk("dc_step1", dc, 1);
    drive(1, 1, 2, 1, 0); chk("dc_step2", dc, 2);
    drive(1, 1, 3, 1, 0); chk("dc_step3", dc, 3);
    drive(1, 1, 4, 1, 0); chk("dc_wrap", dc, 0); chk("fb_not_yet0", fb, 0);
    idle(1); chk("fb_not_yet1", fb, 0);
    idle(1); chk("grant_fb", fb, 1); chk("grant_status", status, 1); chk("model_fb", m_fb, 1);
    drive(1, 1, 0, 0, 1);
    idle(1); chk("logout_fb", fb, 0); chk("logout_status", status, 0);
    code4(16'h1235); idle(2);
    chk("deny_status", status, 2); chk("deny_fc", fc, 1); chk("deny_fb", fb, 0);
    code4(PASS); idle(2);
    chk("regrant_fb", fb, 1); chk("regrant_fc", fc, 0);
    drive(1, 1, 0, 0, 1); idle(1);
    repeat (3) begin code4(16'h0000); idle(2); end
    chk("lock_locked", locked, 1); chk("lock_status", status, 3); chk("lock_fc", fc, 3);
    chk("model_locked", m_locked, 1);
    repeat (5) drive(1, 1, 7, 1, 0);
    chk("lock_ignores_enter", dc, 0);
    idle(2); chk("lock_still", locked, 1);
    idle(1); chk("unlock_locked", locked, 0); chk("unlock_fc", fc, 0); chk("unlock_status", status, 0);
    drive(1, 1, 1, 1, 0); drive(1, 1, 2, 1, 0); chk("abort_dc2", dc, 2);
    drive(1, 0, 0, 0, 0); chk("abort_dc0", dc, 0);
    code4(PASS); idle(2); chk("abort_grant", fb, 1);
    repeat (2) drive(1, 0, 0, 0, 0);
    chk("grant_hold_no_enable", fb, 1);
    drive(1, 1, 9, 1, 1); idle(1);
    chk("logout_wins_fb", fb, 0); chk("logout_wins_dc", dc, 0);
    repeat (3) begin code4(16'h0000); idle(2); end
    chk("relock", locked, 1);
    drive(0, 1, 0, 0, 0);
    chk("rst_lock_locked", locked, 0); chk("rst_lock_status", status, 0); chk("rst_lock_fc", fc, 0);
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] nib;
      nib = 4'(PASS >> (4 * (3 - digs.size())));
      drive($urandom_range(0, 299) != 0, $urandom_range(0, 14) != 0,
            $urandom_range(0, 2) != 0 ? nib : 4'($urandom_range(0, 15)),
            $urandom_range(0, 1) == 1, $urandom_range(0, 19) == 0);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
